// File: rtl/wbq_pkg.sv
// Shared constants and entry type for the register-file write-back queue.
package wbq_pkg;

  localparam int WBQ_BITSIZE = 64;
  localparam int WBQ_REGSIZE = 32;
  localparam int WBQ_DEPTH   = 4;
  localparam int WBQ_SELW    = $clog2(WBQ_REGSIZE);
  localparam int ZERO_REG    = WBQ_REGSIZE - 1;

  typedef struct packed {
    logic [WBQ_SELW-1:0]    sel;
    logic [WBQ_BITSIZE-1:0] data;
  } wb_entry_t;

  function automatic int zero_reg(input int regsize);
    return regsize - 1;
  endfunction

endpackage

// File: rtl/wbq_fwd_match.sv
// Forwarding lookup over the pending queue entries; youngest match wins, scanned back from tail.
module wbq_fwd_match
  import wbq_pkg::*;
#(
  parameter int BITSIZE = WBQ_BITSIZE,
  parameter int SW      = WBQ_SELW,
  parameter int DEPTH   = WBQ_DEPTH
) (
  input  logic [DEPTH-1:0][SW-1:0]      i_sel,
  input  logic [DEPTH-1:0][BITSIZE-1:0] i_data,
  input  logic [$clog2(DEPTH)-1:0]      i_tail,
  input  logic [$clog2(DEPTH):0]        i_count,
  input  logic [SW-1:0]                 i_look_sel,
  output logic                          o_hit,
  output logic [BITSIZE-1:0]            o_data
);

  localparam int PW = $clog2(DEPTH);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Offset i counts back from the newest entry; only the first hit is kept.
      if (!o_hit && ((PW+1)'(i) < i_count) &&
          (i_sel[i_tail - PW'(i + 1)] == i_look_sel)) begin
        o_hit  = 1'b1;
        o_data = i_data[i_tail - PW'(i + 1)];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO draining one entry per cycle into the register file.
// Define WBQ_FORWARD_EN to build the newest-pending-value lookup on look_sel.
module regfile_wb_queue
  import wbq_pkg::*;
#(
  parameter int BITSIZE = WBQ_BITSIZE,
  parameter int REGSIZE = WBQ_REGSIZE,
  parameter int DEPTH   = WBQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(REGSIZE)-1:0] in_sel,
  input  logic [BITSIZE-1:0]         in_data,
  input  logic                       wr_hold,
  output logic                       wr_en,
  output logic [$clog2(REGSIZE)-1:0] wr_sel,
  output logic [BITSIZE-1:0]         wr_data,
  input  logic [$clog2(REGSIZE)-1:0] look_sel,
  output logic                       look_hit,
  output logic [BITSIZE-1:0]         look_data,
  output logic                       empty
);

  localparam int              SW   = $clog2(REGSIZE);
  localparam int              PW   = $clog2(DEPTH);
  localparam logic [SW-1:0]   ZSEL = SW'(zero_reg(REGSIZE));
  localparam logic [PW:0]     FULL = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][SW-1:0]      r_sel;
  logic [DEPTH-1:0][BITSIZE-1:0] r_data;
  logic [PW-1:0]                 r_head;
  logic [PW-1:0]                 r_tail;
  logic [PW:0]                   r_count;

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty  = (r_count == '0);
  assign empty    = w_empty;
  assign in_ready = (r_count < FULL);

  // Writes to the zero register complete the handshake but never occupy a slot.
  assign w_push = in_valid && in_ready && (in_sel != ZSEL);
  assign w_pop  = !w_empty && !wr_hold;

  assign wr_en   = w_pop;
  assign wr_sel  = w_empty ? '0 : r_sel[r_head];
  assign wr_data = w_empty ? '0 : r_data[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_sel   <= '0;
      r_data  <= '0;
    end else begin
      if (w_push) begin
        r_sel[r_tail]  <= in_sel;
        r_data[r_tail] <= in_data;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PW+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (PW+1)'(1);
      end
    end
  end

`ifdef WBQ_FORWARD_EN
  wbq_fwd_match #(
    .BITSIZE (BITSIZE),
    .SW      (SW),
    .DEPTH   (DEPTH)
  ) u_fwd (
    .i_sel      (r_sel),
    .i_data     (r_data),
    .i_tail     (r_tail),
    .i_count    (r_count),
    .i_look_sel (look_sel),
    .o_hit      (look_hit),
    .o_data     (look_data)
  );
`else
  logic w_unused_look;
  assign w_unused_look = ^look_sel;
  assign look_hit      = 1'b0;
  assign look_data     = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_regfile_wb_queue;
  import wbq_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_sel;
  logic [63:0] in_data;
  logic        wr_hold;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic [63:0] wr_data;
  logic [4:0]  look_sel;
  logic        look_hit;
  logic [63:0] look_data;
  logic        empty;

  regfile_wb_queue #(
    .BITSIZE (64),
    .REGSIZE (32),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .wr_hold   (wr_hold),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .look_sel  (look_sel),
    .look_hit  (look_hit),
    .look_data (look_data),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  wb_entry_t   q[$];
  logic        m_push, m_pop, m_rst;
  logic [4:0]  m_sel;
  logic [63:0] m_data;

  typedef struct {
    logic        v;
    logic [4:0]  s;
    logic [63:0] d;
    logic        h;
    logic        en;
    logic [4:0]  wsel;
    logic [63:0] wdat;
    logic        emp;
    logic        rdy;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, then compare outputs against the queue model at negedge.
  task automatic drive_check(input logic v, input logic [4:0] s, input logic [63:0] d,
                             input logic h, input logic [4:0] l, input logic r);
    int          n;
    logic        e_emp;
    logic        e_hit;
    logic [63:0] e_ld;
    rst = r; in_valid = v; in_sel = s; in_data = d; wr_hold = h; look_sel = l;
    @(negedge clk);
    n     = q.size();
    e_emp = (n == 0);
    chk("empty", empty, e_emp);
    chk("in_ready", in_ready, n < DEPTH);
    chk("wr_en", wr_en, !e_emp && !h);
    if (e_emp) begin
      chk("wr_sel", wr_sel, 0);
      chk("wr_data", wr_data, 0);
    end else begin
      chk("wr_sel", wr_sel, q[0].sel);
      chk("wr_data", wr_data, q[0].data);
    end
    e_hit = 1'b0;
    e_ld  = '0;
`ifdef WBQ_FORWARD_EN
    foreach (q[i]) begin
      if (q[i].sel == l) begin
        e_hit = 1'b1;
        e_ld  = q[i].data;
      end
    end
    chk("look_hit", look_hit, e_hit);
    if (e_hit) chk("look_data", look_data, e_ld);
`else
    chk("look_hit", look_hit, e_hit);
    chk("look_data", look_data, e_ld);
`endif
    m_rst  = r;
    m_pop  = !e_emp && !h;
    m_push = v && (n < DEPTH) && (s != 5'd31);
    m_sel  = s;
    m_data = d;
  endtask

  task automatic edge_adv();
    @(posedge clk);
    if (m_rst) begin
      q.delete();
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back('{sel: m_sel, data: m_data});
    end
    #1;
  endtask

  task automatic cyc(input logic v, input logic [4:0] s, input logic [63:0] d,
                     input logic h, input logic [4:0] l, input logic r);
    drive_check(v, s, d, h, l, r);
    edge_adv();
  endtask

  initial begin
    //          v  s   d         h  en sel dat       emp rdy
    tbl[0]  = '{1, 5,  64'hAA,   0, 0, 0,  64'h0,    1,  1};
    tbl[1]  = '{0, 0,  64'h0,    0, 1, 5,  64'hAA,   0,  1};
    tbl[2]  = '{0, 0,  64'h0,    0, 0, 0,  64'h0,    1,  1};
    tbl[3]  = '{1, 1,  64'h11,   1, 0, 0,  64'h0,    1,  1};
    tbl[4]  = '{1, 2,  64'h22,   1, 0, 1,  64'h11,   0,  1};
    tbl[5]  = '{1, 3,  64'h33,   1, 0, 1,  64'h11,   0,  1};
    tbl[6]  = '{1, 4,  64'h44,   1, 0, 1,  64'h11,   0,  1};
    tbl[7]  = '{1, 6,  64'h66,   1, 0, 1,  64'h11,   0,  0};
    tbl[8]  = '{0, 0,  64'h0,    0, 1, 1,  64'h11,   0,  0};
    tbl[9]  = '{0, 0,  64'h0,    0, 1, 2,  64'h22,   0,  1};
    tbl[10] = '{0, 0,  64'h0,    0, 1, 3,  64'h33,   0,  1};
    tbl[11] = '{0, 0,  64'h0,    0, 1, 4,  64'h44,   0,  1};
    tbl[12] = '{0, 0,  64'h0,    0, 0, 0,  64'h0,    1,  1};
    tbl[13] = '{1, 31, 64'hFF,   0, 0, 0,  64'h0,    1,  1};
    tbl[14] = '{0, 0,  64'h0,    0, 0, 0,  64'h0,    1,  1};
    tbl[15] = '{0, 0,  64'h0,    0, 0, 0,  64'h0,    1,  1};
    tbl[16] = '{1, 9,  64'h99,   0, 0, 0,  64'h0,    1,  1};
    tbl[17] = '{1, 10, 64'hA0,   0, 1, 9,  64'h99,   0,  1};
    tbl[18] = '{0, 0,  64'h0,    0, 1, 10, 64'hA0,   0,  1};
    tbl[19] = '{0, 0,  64'h0,    0, 0, 0,  64'h0,    1,  1};

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; wr_hold = 1'b0; look_sel = '0;
    m_push = 1'b0; m_pop = 1'b0; m_rst = 1'b0; m_sel = '0; m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and ten idle cycles.
    drive_check(0, 0, 0, 0, 0, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_look_hit", look_hit, 0);
    chk("rst_look_data", look_data, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in_ready", in_ready, 1);
    edge_adv();
    for (int i = 0; i < 9; i++) begin
      drive_check(0, 0, 0, 0, 0, 0);
      chk("idle_wr_en", wr_en, 0);
      edge_adv();
    end

    for (int i = 0; i < 20; i++) begin
      drive_check(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].h, 5'd0, 1'b0);
      chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].en);
      chk($sformatf("tbl%0d_wr_sel", i), wr_sel, tbl[i].wsel);
      chk($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].wdat);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].emp);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
      edge_adv();
    end

    // Forwarding: two pending writes to r7, newest must win; current input not searched.
    cyc(1, 7, 64'h10, 1, 7, 0);
    cyc(1, 7, 64'h20, 1, 7, 0);
    drive_check(0, 0, 0, 1, 7, 0);
`ifdef WBQ_FORWARD_EN
    chk("fwd_hit7", look_hit, 1);
    chk("fwd_data7", look_data, 64'h20);
`else
    chk("fwd_hit7", look_hit, 0);
    chk("fwd_data7", look_data, 0);
`endif
    edge_adv();
    drive_check(0, 0, 0, 1, 8, 0);
    chk("fwd_hit8", look_hit, 0);
    edge_adv();
    repeat (3) cyc(0, 0, 0, 0, 7, 0);

    // Reset in the middle of a drain drops what is left.
    cyc(1, 1, 64'h101, 1, 0, 0);
    cyc(1, 2, 64'h102, 1, 0, 0);
    cyc(1, 3, 64'h103, 1, 0, 0);
    drive_check(0, 0, 0, 0, 0, 0);
    chk("mid_pop_sel", wr_sel, 1);
    edge_adv();
    drive_check(0, 0, 0, 0, 0, 1);
    chk("mid_rst_cycle_en", wr_en, 1);
    edge_adv();
    for (int i = 0; i < 5; i++) begin
      drive_check(0, 0, 0, 0, 0, 0);
      chk("post_rst_empty", empty, 1);
      chk("post_rst_wr_en", wr_en, 0);
      edge_adv();
    end

    // Random traffic, alternating hold-heavy and drain-heavy phases.
    for (int k = 0; k < 600; k++) begin
      logic        v, h, r;
      logic [4:0]  s, l;
      logic [63:0] d;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      h = ((k % 100) < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      l = 5'($urandom_range(0, 8));
      r = ($urandom_range(0, 79) == 0);
      cyc(v, s, d, h, l, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
